mem_access_ctrl: RTL and testbench

Sequences data-memory loads and stores issued by the memory stage of the core pipeline onto a single-outstanding data bus. It holds the pipeline while the access is in flight. It also forms byte enables and lane-shifted store data, then aligns and extends load data. It sits between the memory-stage pipeline register and the data-memory port and is the only master of that port.

---
 rtl/core_pkg.sv | 20 ++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core's load/store path.
package core_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I load/store width and sign encodings carried in funct3.
  localparam logic [2:0] LS_B  = 3'd0;
  localparam logic [2:0] LS_H  = 3'd1;
  localparam logic [2:0] LS_W  = 3'd2;
  localparam logic [2:0] LS_BU = 3'd4;
  localparam logic [2:0] LS_HU = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp,
    StDone
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data-memory accesses: forms byte enables and
// replicated store data, and selects and extends the load lane.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_raw,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  // Move the addressed byte/half down to bit 0 of the word.
  always_comb begin
    byte_shift = rdata_raw >> {addr_lo, 3'b000};
    half_shift = rdata_raw >> {addr_lo[1], 4'b0000};
    byte_lane  = byte_shift[7:0];
    half_lane  = half_shift[15:0];
  end

  // Store side: enables, replicated data, and legality of the width/offset pair.
  always_comb begin
    be         = 4'b0000;
    wdata_sh   = wdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      LS_B, LS_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
      end
      LS_H, LS_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_sh   = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      LS_W: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load side: sign- or zero-extend the selected lane.
  always_comb begin
    rdata_ext = '0;
    case (funct3)
      LS_B:    rdata_ext = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LS_BU:   rdata_ext = {{(XLEN-8){1'b0}}, byte_lane};
      LS_H:    rdata_ext = {{(XLEN-16){half_lane[15]}}, half_lane};
      LS_HU:   rdata_ext = {{(XLEN-16){1'b0}}, half_lane};
      LS_W:    rdata_ext = rdata_raw;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer: single outstanding access on the data bus,
// holds the pipeline while the access is in flight.
module mem_access_ctrl #(
  parameter int unsigned XLEN   = 32,  // only 32 is supported
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata
);

  core_pkg::mem_state_e state_q;

  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic            new_acc;
  logic            acc_bad;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misaligned;
  logic            al_illegal;

  // One aligner serves both directions: it decodes the incoming request while idle
  // and extends the returned word using the latched width/offset otherwise.
  always_comb begin
    if (state_q == core_pkg::StIdle) begin
      al_funct3  = req_funct3;
      al_addr_lo = req_addr[1:0];
    end else begin
      al_funct3  = funct3_q;
      al_addr_lo = addr_lo_q;
    end
  end

  mem_lane_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (req_wdata),
    .rdata_raw  (bus_rdata),
    .be         (al_be),
    .wdata_sh   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  // Request decode and the combinational pipeline hold.
  always_comb begin
    new_acc = req_valid & (req_read | req_write);
    acc_bad = al_misaligned | al_illegal;
    stall   = ((state_q == core_pkg::StIdle) & new_acc & ~acc_bad) |
              (state_q == core_pkg::StReq) | (state_q == core_pkg::StWaitRsp);
  end

  // Access sequencer with registered bus fields and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= core_pkg::StIdle;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= 4'b0000;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      unique case (state_q)
        core_pkg::StIdle: begin
          if (new_acc) begin
            if (acc_bad) begin
              fault <= 1'b1;
            end else begin
              funct3_q  <= req_funct3;
              addr_lo_q <= req_addr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= req_write ? al_wdata : '0;
              bus_be    <= req_write ? al_be : 4'b0000;
              state_q   <= core_pkg::StReq;
            end
          end
        end
        core_pkg::StReq: begin
          // A same-cycle rvalid here is not a response to this access.
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state_q <= bus_we ? core_pkg::StDone : core_pkg::StWaitRsp;
          end
        end
        core_pkg::StWaitRsp: begin
          if (bus_rvalid) begin
            rdata       <= al_rdata;
            rdata_valid <= 1'b1;
            state_q     <= core_pkg::StDone;
          end
        end
        core_pkg::StDone: begin
          state_q <= core_pkg::StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(
    .XLEN   (32),
    .ADDR_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid  = 1'b1;
    req_read   = ~wr;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick();
    tick();
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    tick();

    // sw 0x100 with immediate grant
    issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    bus_gnt = 1'b1;
    #1 chk("sw_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("sw_bus_req", {31'd0, bus_req}, 32'd1);
    chk("sw_bus_we", {31'd0, bus_we}, 32'd1);
    chk("sw_bus_addr", bus_addr, 32'h100);
    chk("sw_bus_be", {28'd0, bus_be}, 32'hF);
    chk("sw_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_stall_req", {31'd0, stall}, 32'd1);
    tick();
    bus_gnt = 1'b0;
    chk("sw_stall_done", {31'd0, stall}, 32'd0);
    chk("sw_no_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("sw_req_drop", {31'd0, bus_req}, 32'd0);
    tick();

    // sb 0x103
    issue(1'b1, 3'd0, 32'h103, 32'h000000A5);
    tick();
    req_valid = 1'b0;
    chk("sb_bus_addr", bus_addr, 32'h100);
    chk("sb_bus_be", {28'd0, bus_be}, 32'h8);
    chk("sb_bus_wdata", bus_wdata, 32'hA5A5A5A5);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("sb_done_stall", {31'd0, stall}, 32'd0);
    tick();

    // lb 0x102, rvalid 3 cycles after grant
    issue(1'b0, 3'd0, 32'h102, 32'h0);
    bus_gnt = 1'b1;
    #1 chk("lb_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("lb_bus_we", {31'd0, bus_we}, 32'd0);
    chk("lb_bus_be", {28'd0, bus_be}, 32'd0);
    chk("lb_bus_addr", bus_addr, 32'h100);
    tick();
    bus_gnt = 1'b0;
    chk("lb_stall_w1", {31'd0, stall}, 32'd1);
    tick();
    chk("lb_stall_w2", {31'd0, stall}, 32'd1);
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h12F05634;
    chk("lb_stall_w3", {31'd0, stall}, 32'd1);
    tick();
    bus_rvalid = 1'b0;
    chk("lb_rdata", rdata, 32'hFFFFFFF0);
    chk("lb_rdata_valid", {31'd0, rdata_valid}, 32'd1);
    chk("lb_stall_done", {31'd0, stall}, 32'd0);
    tick();
    chk("lb_valid_pulse", {31'd0, rdata_valid}, 32'd0);
    chk("lb_rdata_hold", rdata, 32'hFFFFFFF0);

    // lbu 0x102, same timing
    issue(1'b0, 3'd4, 32'h102, 32'h0);
    bus_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    bus_gnt = 1'b0;
    tick();
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    chk("lbu_rdata", rdata, 32'h000000F0);
    chk("lbu_rdata_valid", {31'd0, rdata_valid}, 32'd1);
    tick();

    // lh 0x101: misaligned
    issue(1'b0, 3'd1, 32'h101, 32'h0);
    #1 chk("lh_mis_stall", {31'd0, stall}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("lh_mis_fault", {31'd0, fault}, 32'd1);
    chk("lh_mis_bus_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("lh_mis_fault_pulse", {31'd0, fault}, 32'd0);
    chk("lh_mis_bus_req2", {31'd0, bus_req}, 32'd0);

    // funct3=3 at 0x0: illegal
    issue(1'b0, 3'd3, 32'h0, 32'h0);
    #1 chk("f3_ill_stall", {31'd0, stall}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("f3_ill_fault", {31'd0, fault}, 32'd1);
    chk("f3_ill_bus_req", {31'd0, bus_req}, 32'd0);
    tick();

    // lw 0x200 with grant withheld 4 cycles
    issue(1'b0, 3'd2, 32'h200, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_hold_req", {31'd0, bus_req}, 32'd1);
      chk("lw_hold_addr", bus_addr, 32'h200);
      chk("lw_hold_be", {28'd0, bus_be}, 32'd0);
      chk("lw_hold_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFEF00D;
    tick();
    bus_rvalid = 1'b0;
    chk("lw_rdata", rdata, 32'hCAFEF00D);
    chk("lw_rdata_valid", {31'd0, rdata_valid}, 32'd1);
    tick();

    // reset while waiting for a load response
    issue(1'b0, 3'd2, 32'h300, 32'h0);
    bus_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    bus_gnt = 1'b0;
    chk("rstw_stall_wait", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h11223344;
    tick();
    bus_rvalid = 1'b0;
    chk("rstw_late_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    tick();
    chk("rstw_late_rvalid2", {31'd0, rdata_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
